// File: rtl/panda_pkg.sv
// Shared types and limits for the panda data-side interconnect.
// Imported by the arbiter and its round-robin sub-block.
package panda_pkg;

  localparam int unsigned MaxDataReq = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } data_req_t;

endpackage

// File: rtl/panda_rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer.
// Priority only rotates on an accepted grant.
module panda_rr_arbiter #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic            found;
  int              j;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < int'(N); i++) begin
      j = (int'(ptr_q) + i) % int'(N);
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx_o = IdxW'(j);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found && en_i) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found && en_i) begin
      ptr_q <= (int'(idx_o) == int'(N) - 1) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/panda_data_arbiter.sv
// Shares one single-port data memory between NumReq requesters.
// Round-robin grant, one-cycle response on the winner's rvalid.
module panda_data_arbiter
  import panda_pkg::*;
#(
  parameter  int unsigned NumReq   = 2,
  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_i,
  output logic [NumReq-1:0]    gnt_o,
  input  logic [NumReq*32-1:0] addr_i,
  input  logic [NumReq*32-1:0] wdata_i,
  input  logic [NumReq*4-1:0]  we_i,
  output logic [NumReq-1:0]    rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_we_o,
  input  logic [31:0]          mem_rdata_i
);

  if (NumReq < 2 || NumReq > MaxDataReq) begin : g_bad_numreq
    $error("panda_data_arbiter: NumReq out of range");
  end

  data_req_t             reqs [NumReq];
  logic [IdxWidth-1:0]   win_idx;
  logic [IdxWidth-1:0]   rsp_idx_q;
  logic                  rsp_vld_q;

  for (genvar g = 0; g < int'(NumReq); g++) begin : g_unpack
    assign reqs[g] = '{
      addr:  addr_i[g*32 +: 32],
      wdata: wdata_i[g*32 +: 32],
      we:    we_i[g*4 +: 4]
    };
  end

  // Reset gates the enable so nothing is granted while held in reset.
  panda_rr_arbiter #(.N(NumReq)) u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .en_i   (mem_gnt_i & rst_ni),
    .gnt_o  (gnt_o),
    .idx_o  (win_idx)
  );

  assign mem_req_o = (|req_i) & rst_ni;

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = '0;
    if (|req_i) begin
      mem_addr_o  = reqs[win_idx].addr;
      mem_wdata_o = reqs[win_idx].wdata;
      mem_we_o    = reqs[win_idx].we;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_vld_q <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      rsp_vld_q <= |gnt_o;
      if (|gnt_o) rsp_idx_q <= win_idx;
    end
  end

  // A response pending across a reset assertion is dropped at once.
  always_comb begin
    rvalid_o = '0;
    if (rsp_vld_q && rst_ni) rvalid_o[rsp_idx_q] = 1'b1;
  end

  assign rdata_o = mem_rdata_i;

endmodule
